// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch/decode link: instruction stream in, stall and redirect requests back
interface id_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic [DATA_W-1:0] inst_i;
  logic              en_i;
  logic              stall_o;
  logic              br_o;
  logic              j_o;
  logic              jr_o;
  logic [ADDR_W-1:0] addr_br_o;
  logic [ADDR_W-1:0] addr_j_o;
  logic [ADDR_W-1:0] addr_jr_o;

  modport master (
    output pc_i, inst_i, en_i,
    input  stall_o, br_o, j_o, jr_o, addr_br_o, addr_j_o, addr_jr_o
  );

  modport slave (
    input  pc_i, inst_i, en_i,
    output stall_o, br_o, j_o, jr_o, addr_br_o, addr_j_o, addr_jr_o
  );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: decode, branch resolve, 2-slot hazard scoreboard, EX register
// Optional ID_LINK_EN: JAL/JALR write the link address (pc_i) to r31 / rd.
module id_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  id_stage_if.slave         fetch,
  output logic [4:0]        rf_ra_o,
  output logic [4:0]        rf_rb_o,
  input  logic [DATA_W-1:0] rf_rda_i,
  input  logic [DATA_W-1:0] rf_rdb_i,
  output logic              ex_en_o,
  output logic [5:0]        ex_op_o,
  output logic [DATA_W-1:0] ex_opa_o,
  output logic [DATA_W-1:0] ex_opb_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_wr_o,
  output logic              ex_we_o,
  output logic              ex_load_o
);

`ifdef ID_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign opcode       = fetch.inst_i[31:26];
  assign funct        = fetch.inst_i[5:0];
  assign rs           = fetch.inst_i[25:21];
  assign rt           = fetch.inst_i[20:16];
  assign rd           = fetch.inst_i[15:11];
  assign unused_shamt = ^fetch.inst_i[10:6];
  assign rf_ra_o      = rs;
  assign rf_rb_o      = rt;

  logic              uses_rs, uses_rt, dest_we, is_load, is_beq, is_bne, is_j, is_jr, link;
  logic [4:0]        dest;
  logic [DATA_W-1:0] imm;

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    dest    = 5'd0;
    dest_we = 1'b0;
    is_load = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    link    = 1'b0;
    imm     = {{(DATA_W-16){fetch.inst_i[15]}}, fetch.inst_i[15:0]};
    case (opcode)
      6'h00: case (funct)
        6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: begin
          uses_rs = 1'b1; uses_rt = 1'b1; dest = rd; dest_we = 1'b1;
        end
        6'h08: begin uses_rs = 1'b1; is_jr = 1'b1; end
        6'h09: begin
          uses_rs = 1'b1; is_jr = 1'b1;
          if (LINK_EN) begin dest = rd; dest_we = 1'b1; link = 1'b1; end
        end
        default: ;
      endcase
      6'h09, 6'h23: begin
        uses_rs = 1'b1; dest = rt; dest_we = 1'b1; is_load = (opcode == 6'h23);
      end
      6'h0d: begin
        uses_rs = 1'b1; dest = rt; dest_we = 1'b1;
        imm = {{(DATA_W-16){1'b0}}, fetch.inst_i[15:0]};
      end
      6'h0f: begin dest = rt; dest_we = 1'b1; end
      6'h2b: begin uses_rs = 1'b1; uses_rt = 1'b1; end
      6'h04: begin uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; end
      6'h05: begin uses_rs = 1'b1; uses_rt = 1'b1; is_bne = 1'b1; end
      6'h02: is_j = 1'b1;
      6'h03: begin
        is_j = 1'b1;
        if (LINK_EN) begin dest = 5'd31; dest_we = 1'b1; link = 1'b1; end
      end
      default: ;
    endcase
    if (dest == 5'd0) dest_we = 1'b0;
  end

  logic              ex_en_q, ex_en_d, ex_we_q, ex_we_d, ex_load_q, ex_load_d;
  logic [5:0]        ex_op_q, ex_op_d;
  logic [4:0]        ex_wr_q, ex_wr_d;
  logic [DATA_W-1:0] ex_opa_q, ex_opa_d, ex_opb_q, ex_opb_d, ex_imm_q, ex_imm_d;
  logic [4:0]        mem_wr_q, mem_wr_d;
  logic              mem_we_q, mem_we_d, mem_load_q, mem_load_d;

  // Source/slot matches; register 0 is never a dependency.
  logic rs_ex, rt_ex, rs_mem, rt_mem, load_use, br_haz, hazard, stall, go, taken;
  assign rs_ex    = uses_rs && (rs != 5'd0) && ex_we_q  && (rs == ex_wr_q);
  assign rt_ex    = uses_rt && (rt != 5'd0) && ex_we_q  && (rt == ex_wr_q);
  assign rs_mem   = uses_rs && (rs != 5'd0) && mem_we_q && (rs == mem_wr_q);
  assign rt_mem   = uses_rt && (rt != 5'd0) && mem_we_q && (rt == mem_wr_q);
  assign load_use = ex_load_q && (rs_ex || rt_ex);
  assign br_haz   = (is_beq || is_bne || is_jr) &&
                    (rs_ex || rt_ex || (mem_load_q && (rs_mem || rt_mem)));
  assign hazard   = fetch.en_i && (load_use || br_haz);
  assign stall    = hazard || hold_i;
  assign go       = fetch.en_i && !stall;
  assign taken    = (is_beq && (rf_rda_i == rf_rdb_i)) || (is_bne && (rf_rda_i != rf_rdb_i));

  assign fetch.stall_o   = stall;
  assign fetch.j_o       = go && is_j;
  assign fetch.jr_o      = go && !is_j && is_jr;
  assign fetch.br_o      = go && !is_j && !is_jr && taken;
  assign fetch.addr_br_o = fetch.pc_i + {{(ADDR_W-16){fetch.inst_i[15]}}, fetch.inst_i[15:0]};
  assign fetch.addr_j_o  = {fetch.pc_i[ADDR_W-1:26], fetch.inst_i[25:0]};
  assign fetch.addr_jr_o = rf_rda_i[ADDR_W-1:0];

  always_comb begin
    ex_en_d    = ex_en_q;
    ex_op_d    = ex_op_q;
    ex_opa_d   = ex_opa_q;
    ex_opb_d   = ex_opb_q;
    ex_imm_d   = ex_imm_q;
    ex_wr_d    = ex_wr_q;
    ex_we_d    = ex_we_q;
    ex_load_d  = ex_load_q;
    mem_wr_d   = mem_wr_q;
    mem_we_d   = mem_we_q;
    mem_load_d = mem_load_q;
    if (!hold_i) begin
      mem_wr_d   = ex_wr_q;
      mem_we_d   = ex_we_q;
      mem_load_d = ex_load_q;
      if (hazard || !fetch.en_i) begin
        ex_en_d   = 1'b0;
        ex_op_d   = 6'd0;
        ex_opa_d  = '0;
        ex_opb_d  = '0;
        ex_imm_d  = '0;
        ex_wr_d   = 5'd0;
        ex_we_d   = 1'b0;
        ex_load_d = 1'b0;
      end else begin
        ex_en_d   = 1'b1;
        ex_op_d   = (opcode == 6'h00) ? funct : opcode;
        ex_opa_d  = link ? DATA_W'(fetch.pc_i) : rf_rda_i;
        ex_opb_d  = rf_rdb_i;
        ex_imm_d  = imm;
        ex_wr_d   = dest;
        ex_we_d   = dest_we;
        ex_load_d = is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_en_q    <= 1'b0;
      ex_op_q    <= 6'd0;
      ex_opa_q   <= '0;
      ex_opb_q   <= '0;
      ex_imm_q   <= '0;
      ex_wr_q    <= 5'd0;
      ex_we_q    <= 1'b0;
      ex_load_q  <= 1'b0;
      mem_wr_q   <= 5'd0;
      mem_we_q   <= 1'b0;
      mem_load_q <= 1'b0;
    end else begin
      ex_en_q    <= ex_en_d;
      ex_op_q    <= ex_op_d;
      ex_opa_q   <= ex_opa_d;
      ex_opb_q   <= ex_opb_d;
      ex_imm_q   <= ex_imm_d;
      ex_wr_q    <= ex_wr_d;
      ex_we_q    <= ex_we_d;
      ex_load_q  <= ex_load_d;
      mem_wr_q   <= mem_wr_d;
      mem_we_q   <= mem_we_d;
      mem_load_q <= mem_load_d;
    end
  end

  assign ex_en_o   = ex_en_q;
  assign ex_op_o   = ex_op_q;
  assign ex_opa_o  = ex_opa_q;
  assign ex_opb_o  = ex_opb_q;
  assign ex_imm_o  = ex_imm_q;
  assign ex_wr_o   = ex_wr_q;
  assign ex_we_o   = ex_we_q;
  assign ex_load_o = ex_load_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage: decode, hazards, redirects, hold, reset
module tb_id_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        hold_i;
  logic [4:0]  rf_ra_o, rf_rb_o;
  logic [31:0] rf_rda_i, rf_rdb_i;
  logic        ex_en_o, ex_we_o, ex_load_o;
  logic [5:0]  ex_op_o;
  logic [31:0] ex_opa_o, ex_opb_o, ex_imm_o;
  logic [4:0]  ex_wr_o;

  always #5 clk = ~clk;

  id_stage_if #(.ADDR_W(32), .DATA_W(32)) fif ();

  id_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .hold_i(hold_i), .fetch(fif),
    .rf_ra_o(rf_ra_o), .rf_rb_o(rf_rb_o), .rf_rda_i(rf_rda_i), .rf_rdb_i(rf_rdb_i),
    .ex_en_o(ex_en_o), .ex_op_o(ex_op_o), .ex_opa_o(ex_opa_o), .ex_opb_o(ex_opb_o),
    .ex_imm_o(ex_imm_o), .ex_wr_o(ex_wr_o), .ex_we_o(ex_we_o), .ex_load_o(ex_load_o)
  );

  function automatic logic [31:0] rv(input logic [4:0] n);
    return (n == 5'd0) ? 32'h0 : 32'h100 + {27'd0, n};
  endfunction

  // Register file model: rN holds 0x100+N, r0 reads zero.
  assign rf_rda_i = rv(rf_ra_o);
  assign rf_rdb_i = rv(rf_rb_o);

  typedef struct {
    logic        en, we, load;
    logic [4:0]  wr;
    logic [31:0] opa, opb;
    logic [5:0]  op;
  } ex_t;

  ex_t exp_q[$];
  ex_t last_exp;
  ex_t bub;
  int  checks = 0;
  int  errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic ex_t mk(input logic en, we, load, input logic [4:0] wr,
                             input logic [31:0] opa, opb, input logic [5:0] op);
    ex_t e;
    e.en = en; e.we = we; e.load = load; e.wr = wr; e.opa = opa; e.opb = opb; e.op = op;
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s, t, d);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tg);
    return {op, tg};
  endfunction

  // redir: 0 none, 1 br, 2 j, 3 jr
  task automatic put(input logic en, input logic [31:0] inst, pc, input logic hold, stall,
                     input logic [1:0] redir, input ex_t ex);
    fif.en_i = en; fif.inst_i = inst; fif.pc_i = pc; hold_i = hold;
    #2;
    check_eq("stall", fif.stall_o, stall);
    check_eq("br", fif.br_o, redir == 2'd1);
    check_eq("j", fif.j_o, redir == 2'd2);
    check_eq("jr", fif.jr_o, redir == 2'd3);
    if (hold) exp_q.push_back(last_exp);
    else if (stall || !en) exp_q.push_back(bub);
    else exp_q.push_back(ex);
  endtask

  task automatic tick();
    ex_t e;
    @(posedge clk);
    #1;
    check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      check_eq("ex_en", ex_en_o, e.en);
      check_eq("ex_we", ex_we_o, e.we);
      check_eq("ex_load", ex_load_o, e.load);
      if (e.we) check_eq("ex_wr", ex_wr_o, e.wr);
      if (e.en) begin
        check_eq("ex_op", ex_op_o, e.op);
        check_eq("ex_opa", ex_opa_o, e.opa);
        check_eq("ex_opb", ex_opb_o, e.opb);
      end
    end
  endtask

  initial begin
    bub = mk(0, 0, 0, 0, 0, 0, 0);
    last_exp = bub;
    reset = 1'b1; hold_i = 1'b0;
    fif.en_i = 1'b0; fif.inst_i = 32'h0; fif.pc_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_ex_en", ex_en_o, 0);
    check_eq("rst_ex_we", ex_we_o, 0);
    check_eq("rst_ex_load", ex_load_o, 0);
    check_eq("rst_ex_wr", ex_wr_o, 0);
    check_eq("rst_ex_opa", ex_opa_o, 0);
    check_eq("rst_stall", fif.stall_o, 0);
    #2;

    put(1, r_ins(6'h21, 1, 2, 3), 32'h1, 0, 0, 0, mk(1, 1, 0, 3, rv(1), rv(2), 6'h21)); tick();

    // Load-use: one bubble then the consumer issues.
    put(1, i_ins(6'h23, 1, 5, 16'h0), 32'h2, 0, 0, 0, mk(1, 1, 1, 5, rv(1), rv(5), 6'h23)); tick();
    put(1, r_ins(6'h21, 5, 1, 6), 32'h3, 0, 1, 0, bub); tick();
    put(1, r_ins(6'h21, 5, 1, 6), 32'h3, 0, 0, 0, mk(1, 1, 0, 6, rv(5), rv(1), 6'h21)); tick();

    put(1, i_ins(6'h04, 1, 1, 16'h4), 32'h11, 0, 0, 1, mk(1, 0, 0, 0, rv(1), rv(1), 6'h04));
    check_eq("addr_br_beq", fif.addr_br_o, 32'h15); tick();
    put(1, i_ins(6'h05, 1, 1, 16'h4), 32'h12, 0, 0, 0, mk(1, 0, 0, 0, rv(1), rv(1), 6'h05));
    check_eq("addr_br_bne", fif.addr_br_o, 32'h16); tick();
    put(1, i_ins(6'h05, 1, 2, 16'hfffe), 32'h30, 0, 0, 1, mk(1, 0, 0, 0, rv(1), rv(2), 6'h05));
    check_eq("addr_br_neg", fif.addr_br_o, 32'h2e); tick();

    put(1, j_ins(6'h02, 26'h100), 32'h8000_0001, 0, 0, 2, mk(1, 0, 0, 0, 0, 0, 6'h02));
    check_eq("addr_j", fif.addr_j_o, 32'h8000_0100); tick();

    // Branch after load: two stall cycles.
    put(1, i_ins(6'h23, 2, 7, 16'h0), 32'h40, 0, 0, 0, mk(1, 1, 1, 7, rv(2), rv(7), 6'h23)); tick();
    put(1, r_ins(6'h08, 7, 0, 0), 32'h41, 0, 1, 0, bub); tick();
    put(1, r_ins(6'h08, 7, 0, 0), 32'h41, 0, 1, 0, bub); tick();
    put(1, r_ins(6'h08, 7, 0, 0), 32'h41, 0, 0, 3, mk(1, 0, 0, 0, rv(7), 0, 6'h08));
    check_eq("addr_jr", fif.addr_jr_o, 32'h107); tick();

    // Branch after ALU op: one stall cycle, then not taken.
    put(1, r_ins(6'h21, 1, 2, 11), 32'h50, 0, 0, 0, mk(1, 1, 0, 11, rv(1), rv(2), 6'h21)); tick();
    put(1, i_ins(6'h04, 11, 1, 16'h2), 32'h51, 0, 1, 0, bub); tick();
    put(1, i_ins(6'h04, 11, 1, 16'h2), 32'h51, 0, 0, 0, mk(1, 0, 0, 0, rv(11), rv(1), 6'h04)); tick();

    for (int k = 0; k < 3; k++) begin
      put(1, i_ins(6'h0d, 1, 9, 16'h8005), 32'h60, 1, 1, 0, bub); tick();
    end
    put(1, i_ins(6'h0d, 1, 9, 16'h8005), 32'h60, 0, 0, 0, mk(1, 1, 0, 9, rv(1), rv(9), 6'h0d)); tick();
    check_eq("imm_ori", ex_imm_o, 32'h0000_8005);
    put(1, i_ins(6'h09, 1, 10, 16'hffff), 32'h61, 0, 0, 0, mk(1, 1, 0, 10, rv(1), rv(10), 6'h09)); tick();
    check_eq("imm_addiu", ex_imm_o, 32'hffff_ffff);

    // Redirect suppressed while held, re-issued on release.
    put(1, j_ins(6'h02, 26'h2000), 32'h70, 1, 1, 0, bub); tick();
    put(1, j_ins(6'h02, 26'h2000), 32'h70, 0, 0, 2, mk(1, 0, 0, 0, 0, 0, 6'h02));
    check_eq("addr_j_rel", fif.addr_j_o, 32'h2000); tick();

    put(1, r_ins(6'h21, 1, 2, 0), 32'h71, 0, 0, 0, mk(1, 0, 0, 0, rv(1), rv(2), 6'h21)); tick();
    put(1, i_ins(6'h3f, 1, 2, 16'h0), 32'h72, 0, 0, 0, mk(1, 0, 0, 0, rv(1), rv(2), 6'h3f)); tick();
    put(0, r_ins(6'h21, 1, 2, 3), 32'h73, 0, 0, 0, bub); tick();

`ifdef ID_LINK_EN
    put(1, j_ins(6'h03, 26'h40), 32'h21, 0, 0, 2, mk(1, 1, 0, 31, 32'h21, 0, 6'h03));
`else
    put(1, j_ins(6'h03, 26'h40), 32'h21, 0, 0, 2, mk(1, 0, 0, 0, 0, 0, 6'h03));
`endif
    check_eq("addr_jal", fif.addr_j_o, 32'h40); tick();

    // Reset during a load-use stall clears the scoreboard.
    put(1, i_ins(6'h23, 1, 12, 16'h0), 32'h80, 0, 0, 0, mk(1, 1, 1, 12, rv(1), rv(12), 6'h23)); tick();
    put(1, r_ins(6'h21, 12, 1, 13), 32'h81, 0, 1, 0, bub);
    reset = 1'b1;
    tick();
    check_eq("stall_after_reset", fif.stall_o, 0);
    reset = 1'b0;
    put(1, r_ins(6'h21, 12, 1, 13), 32'h81, 0, 0, 0, mk(1, 1, 0, 13, rv(12), rv(1), 6'h21)); tick();

    check_eq("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
